// File: rtl/lsu_mem_ctrl_if.sv
// Handshake and RAM-side bundle for lsu_mem_ctrl: CPU request/response channel
// plus the byte-enabled synchronous RAM port. The slave modport is the controller.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 14
);
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_rden;
    logic              ram_wren;
    logic [3:0]        ram_byteena;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready, ram_rdata,
        output req_ready, resp_valid, resp_data, resp_err,
        output ram_addr, ram_rden, ram_wren, ram_byteena, ram_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, resp_ready, ram_rdata,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  ram_addr, ram_rden, ram_wren, ram_byteena, ram_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Big-endian load/store controller in front of a byte-enabled synchronous RAM.
// Define LSU_RANGE_CHECK_EN to reject addresses beyond the RAM instead of aliasing them.
module lsu_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int RAM_AW  = 14,
    parameter int RAM_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_ctrl_if.slave  bus
);
    localparam logic [7:0] OP_LB  = 8'd1, OP_LH  = 8'd2, OP_LW = 8'd3, OP_LBU = 8'd4,
                           OP_LHU = 8'd5, OP_SB  = 8'd6, OP_SH = 8'd7, OP_SW  = 8'd8;
    localparam logic [1:0] LAT_M1 = 2'(RAM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    state_t            r_state, w_state_next;
    logic [7:0]        r_op;
    logic [1:0]        r_off;
    logic [1:0]        r_cnt;

    logic              r_resp_valid, w_resp_valid_next;
    logic [31:0]       r_resp_data, w_resp_data_next;
    logic              r_resp_err, w_resp_err_next;
    logic [RAM_AW-1:0] r_ram_addr, w_ram_addr_next;
    logic              r_ram_rden, w_ram_rden_next;
    logic              r_ram_wren, w_ram_wren_next;
    logic [3:0]        r_ram_byteena, w_ram_byteena_next;
    logic [31:0]       r_ram_wdata, w_ram_wdata_next;

    logic              w_accept, w_is_byte, w_is_half, w_is_word, w_is_store;
    logic              w_misalign, w_oor, w_req_err, w_r_store;
    logic [1:0]        w_in_off;

    function automatic logic [31:0] f_load(input logic [7:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*(3-off) +: 8];
        h = off[1] ? w[15:0] : w[31:16];
        case (op)
            OP_LB:   f_load = {{24{b[7]}}, b};
            OP_LBU:  f_load = {24'd0, b};
            OP_LH:   f_load = {{16{h[15]}}, h};
            OP_LHU:  f_load = {16'd0, h};
            OP_LW:   f_load = w;
            default: f_load = 32'd0;
        endcase
    endfunction

    assign w_in_off   = bus.req_addr[1:0];
    assign w_accept   = bus.req_valid && (r_state == S_IDLE);
    assign w_is_byte  = (bus.req_op == OP_LB) || (bus.req_op == OP_LBU) || (bus.req_op == OP_SB);
    assign w_is_half  = (bus.req_op == OP_LH) || (bus.req_op == OP_LHU) || (bus.req_op == OP_SH);
    assign w_is_word  = (bus.req_op == OP_LW) || (bus.req_op == OP_SW);
    assign w_is_store = (bus.req_op == OP_SB) || (bus.req_op == OP_SH) || (bus.req_op == OP_SW);
    assign w_misalign = (w_is_half && w_in_off[0]) || (w_is_word && (w_in_off != 2'd0));
    assign w_r_store  = (r_op == OP_SB) || (r_op == OP_SH) || (r_op == OP_SW);

`ifdef LSU_RANGE_CHECK_EN
    assign w_oor = |(bus.req_addr >> (RAM_AW + 2));
`else
    // Upper address bits are deliberately dropped: the RAM aliases across the address space.
    logic w_unused_hi;
    assign w_oor       = 1'b0;
    assign w_unused_hi = ^bus.req_addr[ADDR_W-1:RAM_AW+2];
`endif

    assign w_req_err = !(w_is_byte || w_is_half || w_is_word) || w_misalign || w_oor;

    // Outputs are registered from the next-state values so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_op          <= 8'd0;
            r_off         <= 2'd0;
            r_cnt         <= 2'd0;
            r_resp_valid  <= 1'b0;
            r_resp_data   <= 32'd0;
            r_resp_err    <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_rden    <= 1'b0;
            r_ram_wren    <= 1'b0;
            r_ram_byteena <= 4'd0;
            r_ram_wdata   <= 32'd0;
        end else begin
            r_state       <= w_state_next;
            if (w_accept) begin
                r_op  <= bus.req_op;
                r_off <= w_in_off;
            end
            if (r_state == S_ACCESS)
                r_cnt <= LAT_M1;
            else if ((r_state == S_WAIT) && (r_cnt != 2'd0))
                r_cnt <= r_cnt - 2'd1;
            r_resp_valid  <= w_resp_valid_next;
            r_resp_data   <= w_resp_data_next;
            r_resp_err    <= w_resp_err_next;
            r_ram_addr    <= w_ram_addr_next;
            r_ram_rden    <= w_ram_rden_next;
            r_ram_wren    <= w_ram_wren_next;
            r_ram_byteena <= w_ram_byteena_next;
            r_ram_wdata   <= w_ram_wdata_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = w_req_err ? S_RESP : S_ACCESS;
            S_ACCESS: w_state_next = w_r_store ? S_RESP : S_WAIT;
            S_WAIT:   if (r_cnt == 2'd0) w_state_next = S_RESP;
            S_RESP:   if (bus.resp_ready) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_resp_valid_next  = r_resp_valid;
        w_resp_data_next   = r_resp_data;
        w_resp_err_next    = r_resp_err;
        w_ram_addr_next    = r_ram_addr;
        w_ram_rden_next    = 1'b0;
        w_ram_wren_next    = 1'b0;
        w_ram_byteena_next = r_ram_byteena;
        w_ram_wdata_next   = r_ram_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_req_err) begin
                    w_resp_valid_next = 1'b1;
                    w_resp_data_next  = 32'd0;
                    w_resp_err_next   = 1'b1;
                end else if (w_accept) begin
                    w_ram_addr_next = bus.req_addr[RAM_AW+1:2];
                    w_ram_rden_next = !w_is_store;
                    w_ram_wren_next = w_is_store;
                    if (w_is_byte) begin
                        w_ram_byteena_next = 4'b1000 >> w_in_off;
                        w_ram_wdata_next   = {4{bus.req_wdata[7:0]}};
                    end else if (w_is_half) begin
                        w_ram_byteena_next = w_in_off[1] ? 4'b0011 : 4'b1100;
                        w_ram_wdata_next   = {2{bus.req_wdata[15:0]}};
                    end else begin
                        w_ram_byteena_next = 4'b1111;
                        w_ram_wdata_next   = bus.req_wdata;
                    end
                end
            end
            S_ACCESS: begin
                if (w_r_store) begin
                    w_resp_valid_next = 1'b1;
                    w_resp_data_next  = 32'd0;
                    w_resp_err_next   = 1'b0;
                end
            end
            S_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_resp_valid_next = 1'b1;
                    w_resp_data_next  = f_load(r_op, r_off, bus.ram_rdata);
                    w_resp_err_next   = 1'b0;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_resp_valid_next = 1'b0;
                    w_resp_data_next  = 32'd0;
                    w_resp_err_next   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_data   = r_resp_data;
    assign bus.resp_err    = r_resp_err;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_rden    = r_ram_rden;
    assign bus.ram_wren    = r_ram_wren;
    assign bus.ram_byteena = r_ram_byteena;
    assign bus.ram_wdata   = r_ram_wdata;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural byte-enabled RAM of latency 3.
module tb_lsu_mem_ctrl;
    localparam int ADDR_W  = 32;
    localparam int RAM_AW  = 14;
    localparam int RAM_LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) bus ();

    lsu_mem_ctrl #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW), .RAM_LAT(RAM_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:(1<<RAM_AW)-1] = '{default: 32'h0};
    logic [31:0] rd_pipe [0:RAM_LAT-1] = '{default: 32'h0};

    // Reads without ram_rden return a poison pattern so a missed strobe shows up in the data.
    always @(posedge clk) begin
        if (bus.ram_wren)
            for (int b = 0; b < 4; b++)
                if (bus.ram_byteena[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
        rd_pipe[0] <= bus.ram_rden ? mem[bus.ram_addr] : 32'hA5A5_A5A5;
        for (int k = 1; k < RAM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bus.ram_rdata = rd_pipe[RAM_LAT-1];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] t_data, t_wd;
    logic        t_err;
    logic [3:0]  t_be;
    int          t_lat, t_rd, t_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One request/response; holds resp_ready low for 'hold' cycles after resp_valid rises.
    task automatic xact(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, input logic [31:0] bp_exp);
        bus.req_op     = op;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        bus.resp_ready = (hold == 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        t_lat = 0; t_rd = 0; t_wr = 0; t_be = 4'd0; t_wd = 32'd0;
        for (int c = 1; c <= 12 && t_lat == 0; c++) begin
            if (bus.ram_rden) begin t_rd++; t_be = bus.ram_byteena; end
            if (bus.ram_wren) begin t_wr++; t_be = bus.ram_byteena; t_wd = bus.ram_wdata; end
            if (bus.resp_valid) t_lat = c;
            else begin @(posedge clk); #1; end
        end
        t_data = bus.resp_data;
        t_err  = bus.resp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("bp_valid", bus.resp_valid, 1'b1);
            chk("bp_data", bus.resp_data, bp_exp);
            chk("bp_req_ready", bus.req_ready, 1'b0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        $display("op=%0d addr=%h wdata=%h -> data=%h err=%b lat=%0d rd=%0d wr=%0d be=%b",
                 op, addr, wd, t_data, t_err, t_lat, t_rd, t_wr, t_be);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = 8'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_err", bus.resp_err, 1'b0);
        chk("rst_rden", bus.ram_rden, 1'b0);
        chk("rst_wren", bus.ram_wren, 1'b0);
        chk("rst_byteena", bus.ram_byteena, 4'd0);
        chk("rst_ram_addr", bus.ram_addr, 14'd0);
        chk("rst_ram_wdata", bus.ram_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        xact(8'd8, 32'h10, 32'hDEAD_BEEF, 0, 32'd0);
        chk("sw_lat", t_lat, 2);
        chk("sw_err", t_err, 1'b0);
        chk("sw_data", t_data, 32'd0);
        chk("sw_wr", t_wr, 1);
        chk("sw_be", t_be, 4'b1111);
        chk("sw_wdata", t_wd, 32'hDEAD_BEEF);
        chk("sw_single_resp", bus.resp_valid, 1'b0);
        chk("sw_ready_after", bus.req_ready, 1'b1);

        xact(8'd1, 32'h11, 32'd0, 0, 32'd0);
        chk("lb_data", t_data, 32'hFFFF_FFAD);
        chk("lb_lat", t_lat, 2 + RAM_LAT);
        chk("lb_rd", t_rd, 1);
        chk("lb_be", t_be, 4'b0100);

        xact(8'd4, 32'h13, 32'd0, 0, 32'd0);
        chk("lbu_data", t_data, 32'h0000_00EF);
        chk("lbu_lat", t_lat, 2 + RAM_LAT);
        chk("lbu_be", t_be, 4'b0001);

        xact(8'd6, 32'h22, 32'hAAAA_AA7F, 0, 32'd0);
        chk("sb_be", t_be, 4'b0010);
        chk("sb_wdata", t_wd, 32'h7F7F_7F7F);
        chk("sb_lat", t_lat, 2);
        xact(8'd3, 32'h20, 32'd0, 0, 32'd0);
        chk("lw_sb_data", t_data, 32'h0000_7F00);

        xact(8'd2, 32'h01, 32'd0, 0, 32'd0);
        chk("lh_mis_err", t_err, 1'b1);
        chk("lh_mis_data", t_data, 32'd0);
        chk("lh_mis_lat", t_lat, 1);
        chk("lh_mis_strobes", t_rd + t_wr, 0);
        xact(8'd8, 32'h02, 32'h1111_1111, 0, 32'd0);
        chk("sw_mis_err", t_err, 1'b1);
        chk("sw_mis_lat", t_lat, 1);
        chk("sw_mis_strobes", t_rd + t_wr, 0);
        xact(8'd9, 32'h00, 32'd0, 0, 32'd0);
        chk("op9_err", t_err, 1'b1);
        chk("op9_data", t_data, 32'd0);
        chk("op9_lat", t_lat, 1);
        chk("op9_strobes", t_rd + t_wr, 0);
        xact(8'd0, 32'h04, 32'd0, 0, 32'd0);
        chk("op0_err", t_err, 1'b1);
        xact(8'd3, 32'h20, 32'd0, 0, 32'd0);
        chk("mis_no_write", t_data, 32'h0000_7F00);

        xact(8'd8, 32'h10, 32'h1234_ABCD, 0, 32'd0);
        xact(8'd5, 32'h12, 32'd0, 5, 32'h0000_ABCD);
        chk("lhu_data", t_data, 32'h0000_ABCD);
        chk("lhu_be", t_be, 4'b0011);
        chk("lhu_ready_after", bus.req_ready, 1'b1);
        xact(8'd2, 32'h12, 32'd0, 0, 32'd0);
        chk("lh_neg", t_data, 32'hFFFF_ABCD);
        xact(8'd2, 32'h10, 32'd0, 0, 32'd0);
        chk("lh_pos", t_data, 32'h0000_1234);
        chk("lh_be", t_be, 4'b1100);

        xact(8'd7, 32'h30, 32'h5555_BEEF, 0, 32'd0);
        chk("sh_be", t_be, 4'b1100);
        chk("sh_wdata", t_wd, 32'hBEEF_BEEF);
        xact(8'd3, 32'h30, 32'd0, 0, 32'd0);
        chk("lw_sh_data", t_data, 32'hBEEF_0000);

        // Reset in the WAIT state of a load.
        bus.req_op = 8'd3; bus.req_addr = 32'h10; bus.req_valid = 1'b1; bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("mid_access_rden", bus.ram_rden, 1'b1);
        @(posedge clk); #1;
        chk("mid_wait_ready", bus.req_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rden", bus.ram_rden, 1'b0);
        chk("mid_rst_wren", bus.ram_wren, 1'b0);
        chk("mid_rst_ready", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_valid", bus.resp_valid, 1'b0);
        chk("post_rst_ready", bus.req_ready, 1'b1);
        xact(8'd3, 32'h10, 32'd0, 0, 32'd0);
        chk("post_rst_data", t_data, 32'h1234_ABCD);
        chk("post_rst_lat", t_lat, 2 + RAM_LAT);

        xact(8'd8, 32'h00, 32'hCAFE_F00D, 0, 32'd0);
        xact(8'd3, 32'h0001_0000, 32'd0, 0, 32'd0);
`ifdef LSU_RANGE_CHECK_EN
        chk("range_err", t_err, 1'b1);
        chk("range_data", t_data, 32'd0);
        chk("range_lat", t_lat, 1);
        chk("range_strobes", t_rd + t_wr, 0);
`else
        chk("alias_err", t_err, 1'b0);
        chk("alias_data", t_data, 32'hCAFE_F00D);
        chk("alias_lat", t_lat, 2 + RAM_LAT);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
